// File: rtl/i2s_clk_ctrl.sv
// I2S clock master and stream sequencer for the ICS-43432 mic path (sck/ws generation, startup discard, sample gating).
// Latency: rx_vld to dout_vld 1 clk; running/ws/sck registered; rx_rdy combinational.
// Backpressure: dout held until drained; rx_rdy = ~dout_vld | dout_rdy in RUN; overrun flags words lost at ws rise.
// Optional feature macro: I2S_CTRL_STARTUP_EN (adds START state discarding STARTUP_FRAMES frames).
module i2s_clk_ctrl #(
   parameter int SCK_DIV        = 16,
   parameter int BITS_PER_CH    = 32,
   parameter int STARTUP_FRAMES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ovr_clr,
   output logic        sck,
   output logic        ws,
   input  logic [15:0] rx_din,
   input  logic        rx_vld,
   output logic        rx_rdy,
   output logic [15:0] dout,
   output logic        dout_vld,
   input  logic        dout_rdy,
   output logic        running,
   output logic        overrun
);

   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * BITS_PER_CH);

   // Elaboration-time guard on the legal parameter ranges
   if (SCK_DIV < 2 || STARTUP_FRAMES < 1) begin : g_param_chk
      $error("i2s_clk_ctrl: SCK_DIV must be >= 2 and STARTUP_FRAMES >= 1");
   end

`ifdef I2S_CTRL_STARTUP_EN
   typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;
   localparam int FRM_W = $clog2(STARTUP_FRAMES + 1);
`else
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
`endif

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt, bit_nxt;
   logic               div_tc, sck_fall, frame_bnd, ws_rise;
   logic               in_run, load, ovr_set, ovr_start;

   assign div_tc    = (state != IDLE) && (div_cnt == DIV_W'(SCK_DIV - 1));
   assign sck_fall  = div_tc && sck;
   assign frame_bnd = sck_fall && (bit_cnt == BIT_W'(2 * BITS_PER_CH - 1));
   assign ws_rise   = sck_fall && (bit_cnt == BIT_W'(BITS_PER_CH - 1));
   assign bit_nxt   = (bit_cnt == BIT_W'(2 * BITS_PER_CH - 1)) ? '0 : bit_cnt + 1'b1;

   // Divider, sck toggle, bit counter and ws; all frozen at zero in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
         ws      <= 1'b0;
      end else if (state == IDLE) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
         ws      <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= '0;
         sck     <= ~sck;
         if (sck) begin
            bit_cnt <= bit_nxt;
            ws      <= (bit_nxt >= BIT_W'(BITS_PER_CH));
         end
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

`ifdef I2S_CTRL_STARTUP_EN
   logic [FRM_W-1:0] frm_cnt;
   logic             start_done;

   assign start_done = frame_bnd && (frm_cnt == FRM_W'(STARTUP_FRAMES - 1));

   // Counts completed frames while discarding the mic's start-up output
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 frm_cnt <= '0;
      else if (state != START) frm_cnt <= '0;
      else if (frame_bnd)      frm_cnt <= frm_cnt + 1'b1;
   end
`endif

   // Sequencer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a drop of en always wins over startup completion
   always_comb begin
      state_nxt = state;
      case (state)
`ifdef I2S_CTRL_STARTUP_EN
         IDLE:  if (en) state_nxt = START;
         START: begin
            if (!en)            state_nxt = STOP;
            else if (start_done) state_nxt = RUN;
         end
`else
         IDLE:  if (en) state_nxt = RUN;
`endif
         RUN:   if (!en) state_nxt = STOP;
         STOP:  if (frame_bnd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_run    = (state == RUN);
   assign rx_rdy    = in_run ? (~dout_vld | dout_rdy) : 1'b1;
   assign load      = in_run && rx_vld && rx_rdy;
   assign ovr_set   = in_run && ws_rise && rx_vld && !rx_rdy;
   assign ovr_start = (state == IDLE) && (state_nxt != IDLE);

   // Registered running flag tracks the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) running <= 1'b0;
      else     running <= (state_nxt == RUN);
   end

   // Output holding register; a held word drains even after leaving RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else if (load) begin
         dout     <= rx_din;
         dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
         dout_vld <= 1'b0;
      end
   end

   // Sticky overrun; a set in the same cycle as a clear takes priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        overrun <= 1'b0;
      else if (ovr_set)               overrun <= 1'b1;
      else if (ovr_clr || ovr_start)  overrun <= 1'b0;
   end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: SCK_DIV=2, BITS_PER_CH=32, STARTUP_FRAMES=3 (frame = 256 clk).
// Expectations follow I2S_CTRL_STARTUP_EN if it is defined for the build.
// Accepted samples are queued as expected words and popped when dout drains.
module tb_i2s_clk_ctrl;
   logic        clk = 1'b0;
   logic        rst, en, ovr_clr, rx_vld, dout_rdy;
   logic [15:0] rx_din;
   logic        sck, ws, rx_rdy, dout_vld, running, overrun;
   logic [15:0] dout;

   int          pass_cnt = 0;
   int          total    = 0;
   int          edge_no  = 0;
   int          e0       = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
`ifdef I2S_CTRL_STARTUP_EN
   localparam logic STARTUP = 1'b1;
`else
   localparam logic STARTUP = 1'b0;
`endif

   i2s_clk_ctrl #(.SCK_DIV(2), .BITS_PER_CH(32), .STARTUP_FRAMES(3)) dut (
      .clk(clk), .rst(rst), .en(en), .ovr_clr(ovr_clr), .sck(sck), .ws(ws),
      .rx_din(rx_din), .rx_vld(rx_vld), .rx_rdy(rx_rdy), .dout(dout),
      .dout_vld(dout_vld), .dout_rdy(dout_rdy), .running(running), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Scoreboard: every drained word must match the oldest expected one
   always @(negedge clk) begin
      if (rst === 1'b0 && dout_vld === 1'b1 && dout_rdy === 1'b1) begin
         total++;
         if (exp_q.size() == 0) $display("FAIL sb_unexpected: got %h, none expected", dout);
         else begin
            exp_w = exp_q.pop_front();
            if (dout !== exp_w) $display("FAIL sb_data: got %h want %h", dout, exp_w);
            else pass_cnt++;
         end
      end
   end

   task step(input int n);
      repeat (n) @(posedge clk);
      #1;
      edge_no += n;
   endtask

   // Advance to 1 time unit after edge k counted from the enable edge
   task goto(input int k);
      if (e0 + k > edge_no) step(e0 + k - edge_no);
   endtask

   task test_reset;
      rst = 1'b1; en = 1'b0; ovr_clr = 1'b0; rx_vld = 1'b0; dout_rdy = 1'b0; rx_din = 16'h0;
      step(2);
      total++; if (sck !== 1'b0)      $display("FAIL rst_sck: got %b want 0", sck); else pass_cnt++;
      total++; if (ws !== 1'b0)       $display("FAIL rst_ws: got %b want 0", ws); else pass_cnt++;
      total++; if (dout !== 16'h0)    $display("FAIL rst_dout: got %h want 0000", dout); else pass_cnt++;
      total++; if (dout_vld !== 1'b0) $display("FAIL rst_dout_vld: got %b want 0", dout_vld); else pass_cnt++;
      total++; if (running !== 1'b0)  $display("FAIL rst_running: got %b want 0", running); else pass_cnt++;
      total++; if (overrun !== 1'b0)  $display("FAIL rst_overrun: got %b want 0", overrun); else pass_cnt++;
      total++; if (rx_rdy !== 1'b1)   $display("FAIL rst_rx_rdy: got %b want 1", rx_rdy); else pass_cnt++;
      rst = 1'b0;
      step(2);
      total++; if (sck !== 1'b0)      $display("FAIL idle_sck: got %b want 0", sck); else pass_cnt++;
   endtask

   task test_clocking;
      en = 1'b1;
      e0 = edge_no + 1;
      goto(0);
      total++; if (running !== !STARTUP) $display("FAIL en_running: got %b want %b", running, !STARTUP); else pass_cnt++;
      total++; if (sck !== 1'b0) $display("FAIL sck_k0: got %b want 0", sck); else pass_cnt++;
      goto(1);
      total++; if (sck !== 1'b0) $display("FAIL sck_k1: got %b want 0", sck); else pass_cnt++;
      goto(2);
      total++; if (sck !== 1'b1) $display("FAIL sck_first_rise: got %b want 1", sck); else pass_cnt++;
      goto(4);
      total++; if (sck !== 1'b0) $display("FAIL sck_first_fall: got %b want 0", sck); else pass_cnt++;
      goto(6);
      total++; if (sck !== 1'b1) $display("FAIL sck_second_rise: got %b want 1", sck); else pass_cnt++;
   endtask

   task test_first_frame;
      goto(100);
      dout_rdy = 1'b1;
      rx_vld   = 1'b1;
      rx_din   = STARTUP ? 16'h1234 : 16'h0F0F;
      if (!STARTUP) exp_q.push_back(16'h0F0F);
      #1;
      total++; if (rx_rdy !== 1'b1) $display("FAIL f1_rx_rdy: got %b want 1", rx_rdy); else pass_cnt++;
      step(1);
      rx_vld = 1'b0;
      total++; if (dout_vld !== !STARTUP) $display("FAIL f1_dout_vld: got %b want %b", dout_vld, !STARTUP); else pass_cnt++;
   endtask

   task test_ws_frame;
      goto(127);
      total++; if (ws !== 1'b0) $display("FAIL ws_before_rise: got %b want 0", ws); else pass_cnt++;
      goto(128);
      total++; if (ws !== 1'b1) $display("FAIL ws_rise_32: got %b want 1", ws); else pass_cnt++;
      goto(255);
      total++; if (ws !== 1'b1) $display("FAIL ws_before_fall: got %b want 1", ws); else pass_cnt++;
      goto(256);
      total++; if (ws !== 1'b0) $display("FAIL ws_fall_64: got %b want 0", ws); else pass_cnt++;
   endtask

   task test_startup;
      if (STARTUP) begin
         for (int k = 300; k <= 600; k += 300) begin
            goto(k);
            rx_vld = 1'b1; rx_din = 16'h1234; dout_rdy = 1'b1;
            #1;
            total++; if (rx_rdy !== 1'b1) $display("FAIL start_rx_rdy k=%0d: got %b want 1", k, rx_rdy); else pass_cnt++;
            step(1);
            rx_vld = 1'b0;
            total++; if (dout_vld !== 1'b0) $display("FAIL start_drop k=%0d: got %b want 0", k, dout_vld); else pass_cnt++;
         end
      end
      goto(767);
      total++; if (running !== !STARTUP) $display("FAIL running_767: got %b want %b", running, !STARTUP); else pass_cnt++;
      goto(768);
      total++; if (running !== 1'b1) $display("FAIL running_768: got %b want 1", running); else pass_cnt++;
   endtask

   task test_handshake;
      goto(800);
      dout_rdy = 1'b1; rx_vld = 1'b1; rx_din = 16'hBEEF;
      exp_q.push_back(16'hBEEF);
      #1;
      total++; if (rx_rdy !== 1'b1) $display("FAIL hs_rx_rdy: got %b want 1", rx_rdy); else pass_cnt++;
      step(1);
      dout_rdy = 1'b0; rx_din = 16'h5555;
      total++; if (dout_vld !== 1'b1) $display("FAIL hs_dout_vld: got %b want 1", dout_vld); else pass_cnt++;
      total++; if (dout !== 16'hBEEF) $display("FAIL hs_dout: got %h want beef", dout); else pass_cnt++;
   endtask

   task test_overrun;
      #1;
      total++; if (rx_rdy !== 1'b0) $display("FAIL ovr_rx_rdy: got %b want 0", rx_rdy); else pass_cnt++;
      goto(895);
      total++; if (overrun !== 1'b0) $display("FAIL ovr_early: got %b want 0", overrun); else pass_cnt++;
      goto(896);
      total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else pass_cnt++;
      total++; if (dout !== 16'hBEEF) $display("FAIL ovr_dout: got %h want beef", dout); else pass_cnt++;
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0; rx_vld = 1'b0;
      total++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", overrun); else pass_cnt++;
   endtask

   task test_async_reset;
      total++; if (dout_vld !== 1'b1) $display("FAIL arst_pre_vld: got %b want 1", dout_vld); else pass_cnt++;
      total++; if (ws !== 1'b1)       $display("FAIL arst_pre_ws: got %b want 1", ws); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total++; if (ws !== 1'b0)       $display("FAIL arst_ws: got %b want 0", ws); else pass_cnt++;
      total++; if (sck !== 1'b0)      $display("FAIL arst_sck: got %b want 0", sck); else pass_cnt++;
      total++; if (dout !== 16'h0)    $display("FAIL arst_dout: got %h want 0000", dout); else pass_cnt++;
      total++; if (dout_vld !== 1'b0) $display("FAIL arst_dout_vld: got %b want 0", dout_vld); else pass_cnt++;
      total++; if (running !== 1'b0)  $display("FAIL arst_running: got %b want 0", running); else pass_cnt++;
      total++; if (rx_rdy !== 1'b1)   $display("FAIL arst_rx_rdy: got %b want 1", rx_rdy); else pass_cnt++;
      exp_q.delete();
      en = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task test_stop;
      en = 1'b1;
      e0 = edge_no + 1;
      goto(800);
      dout_rdy = 1'b0; rx_vld = 1'b1; rx_din = 16'hA5A5;
      exp_q.push_back(16'hA5A5);
      step(1);
      rx_vld = 1'b0;
      total++; if (dout_vld !== 1'b1) $display("FAIL stop_load: got %b want 1", dout_vld); else pass_cnt++;
      goto(810);
      en = 1'b0;
      goto(811);
      total++; if (running !== 1'b0)  $display("FAIL stop_running: got %b want 0", running); else pass_cnt++;
      total++; if (dout_vld !== 1'b1) $display("FAIL stop_hold: got %b want 1", dout_vld); else pass_cnt++;
      rx_vld = 1'b1; rx_din = 16'h1111;
      #1;
      total++; if (rx_rdy !== 1'b1) $display("FAIL stop_rx_rdy: got %b want 1", rx_rdy); else pass_cnt++;
      step(1);
      rx_vld = 1'b0;
      total++; if (dout !== 16'hA5A5) $display("FAIL stop_no_load: got %h want a5a5", dout); else pass_cnt++;
      dout_rdy = 1'b1;
      step(1);
      total++; if (dout_vld !== 1'b0) $display("FAIL stop_drain: got %b want 0", dout_vld); else pass_cnt++;
      goto(814);
      total++; if (sck !== 1'b1) $display("FAIL stop_sck_runs: got %b want 1", sck); else pass_cnt++;
      goto(900);
      en = 1'b1;
      goto(1023);
      total++; if (sck !== 1'b1 || ws !== 1'b1) $display("FAIL stop_last_bit: got sck=%b ws=%b want 1 1", sck, ws); else pass_cnt++;
      goto(1024);
      total++; if (sck !== 1'b0 || ws !== 1'b0) $display("FAIL stop_idle_clk: got sck=%b ws=%b want 0 0", sck, ws); else pass_cnt++;
      goto(1025);
      total++; if (running !== !STARTUP) $display("FAIL restart_running: got %b want %b", running, !STARTUP); else pass_cnt++;
      goto(1026);
      total++; if (sck !== 1'b0) $display("FAIL restart_sck_1026: got %b want 0", sck); else pass_cnt++;
      goto(1027);
      total++; if (sck !== 1'b1) $display("FAIL restart_sck_rise: got %b want 1", sck); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_clocking();
      test_first_frame();
      test_ws_frame();
      test_startup();
      test_handshake();
      test_overrun();
      test_async_reset();
      test_stop();
      step(2);
      total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d words want 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
